// File: rtl/alu_seq_pkg.sv
// Shared types for the ALU issue/retire stage: FSM states, op bit layout and op record.
package alu_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    HOLD
  } state_t;

  localparam int unsigned OP_ADD   = 0;
  localparam int unsigned OP_SUB   = 1;
  localparam int unsigned OP_CIN   = 2;
  localparam int unsigned OP_ARITH = 3;
  localparam int unsigned OP_BSET  = 4;
  localparam int unsigned OP_W     = 5;

  // Member order mirrors the bit indices above: add is bit 0, bset is bit 4.
  typedef struct packed {
    logic bset;
    logic arith;
    logic cin;
    logic sub;
    logic add;
  } op_t;

endpackage

// File: rtl/alu_sequencer.sv
// Issue/retire stage around a combinational 16-bit ALU; wide ops run as a
// low pass then a carry-chained high pass.
module alu_sequencer
  import alu_seq_pkg::*;
#(
  parameter int unsigned W    = 16,
  parameter bit          WIDE = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2*W-1:0]    in_a,
  input  logic [2*W-1:0]    in_b,
  input  logic [OP_W-1:0]   in_op,
  input  logic [3:0]        in_tt,
  input  logic [3:0]        in_sh_off,
  input  logic              in_wide,
  output logic [W-1:0]      alu_a,
  output logic [W-1:0]      alu_b,
  output logic [OP_W-1:0]   alu_op,
  output logic [3:0]        alu_tt,
  output logic [3:0]        alu_sh_off,
  input  logic [W-1:0]      alu_out,
  input  logic              alu_carry,
  input  logic              alu_ovf,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2*W-1:0]    out_result,
  output logic              out_carry,
  output logic              out_ovf,
  output logic              out_zero
);

  if (W != 16) begin : g_bad_width
    $error("alu_sequencer: W must be 16");
  end

  state_t           state;
  logic [2*W-1:0]   a_r;
  logic [2*W-1:0]   b_r;
  op_t              op_r;
  logic [3:0]       tt_r;
  logic [3:0]       sh_r;
  logic             wide_r;
  logic [2*W-1:0]   res_r;
  logic             carry_r;
  logic             ovf_r;
  op_t              hi_op;
  logic             accept;

  assign in_ready = !rst && ((state == IDLE) || ((state == HOLD) && out_ready));
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      a_r     <= '0;
      b_r     <= '0;
      op_r    <= '0;
      tt_r    <= '0;
      sh_r    <= '0;
      wide_r  <= 1'b0;
      res_r   <= '0;
      carry_r <= 1'b0;
      ovf_r   <= 1'b0;
    end else begin
      unique case (state)
        IDLE, HOLD: begin
          if (accept) begin
            a_r    <= in_a;
            b_r    <= in_b;
            op_r   <= op_t'(in_op);
            tt_r   <= in_tt;
            sh_r   <= in_sh_off;
            wide_r <= in_wide && WIDE;
            state  <= LO;
          end else if ((state == HOLD) && out_ready) begin
            state <= IDLE;
          end
        end
        LO: begin
          // Upper half cleared here so a narrow op never shows a stale high half.
          res_r[2*W-1:W] <= '0;
          res_r[W-1:0]   <= alu_out;
          carry_r        <= alu_carry;
          ovf_r          <= alu_ovf;
          state          <= wide_r ? HI : HOLD;
        end
        HI: begin
          res_r[2*W-1:W] <= alu_out;
          carry_r        <= alu_carry;
          ovf_r          <= alu_ovf;
          state          <= HOLD;
        end
      endcase
    end
  end

  // The low-pass carry stands in for c_in on the high pass of add/sub chains.
  always_comb begin
    hi_op     = op_r;
    hi_op.cin = carry_r;
  end

  always_comb begin
    alu_a      = a_r[W-1:0];
    alu_b      = b_r[W-1:0];
    alu_op     = op_r;
    alu_tt     = tt_r;
    alu_sh_off = sh_r;
    if (state == HI) begin
      alu_a = a_r[2*W-1:W];
      alu_b = b_r[2*W-1:W];
      if (op_r.add) alu_op = hi_op;
    end
  end

  assign out_valid  = (state == HOLD);
  assign out_result = res_r;
  assign out_carry  = carry_r;
  assign out_ovf    = ovf_r;
  assign out_zero   = (res_r == '0);

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: vector table, hand-written corner
// sequences, and randomized ops checked against a 32-bit arithmetic model.
module tb_alu_sequencer;

  logic clk;
  logic rst;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, in_wide, out_ready;
  logic [31:0] in_a, in_b;
  logic [4:0]  in_op;
  logic [3:0]  in_tt, in_sh_off;
  logic [15:0] alu_a, alu_b, alu_out;
  logic [4:0]  alu_op;
  logic [3:0]  alu_tt, alu_sh_off;
  logic        alu_carry, alu_ovf;
  logic        out_valid, out_carry, out_ovf, out_zero;
  logic [31:0] out_result;
  logic [17:0] alu_r;

  logic        in_valid_n, in_ready_n, out_ready_n;
  logic [15:0] alu_a_n, alu_b_n, alu_out_n;
  logic [4:0]  alu_op_n;
  logic [3:0]  alu_tt_n, alu_sh_off_n;
  logic        alu_carry_n, alu_ovf_n;
  logic        out_valid_n, out_carry_n, out_ovf_n, out_zero_n;
  logic [31:0] out_result_n;
  logic [17:0] alu_r_n;

  int checks;
  int failures;
  logic [4:0] op_at2;
  logic [3:0] last_sh;

  // Stand-in for the external ALU: {ovf, carry, result}.
  function automatic logic [17:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                        input logic [4:0] op, input logic [3:0] tt);
    logic [15:0] bb;
    logic [16:0] s;
    logic [15:0] r;
    bb = op[4] ? (b | 16'h0001) : b;
    if (op[0]) begin
      if (op[1]) bb = ~bb;
      s = {1'b0, a} + {1'b0, bb} + 17'(op[2]);
      return {(a[15] == bb[15]) && (s[15] != a[15]), s[16], s[15:0]};
    end
    for (int i = 0; i < 16; i++) r[i] = tt[{a[i], bb[i]}];
    return {2'b00, r};
  endfunction

  assign alu_r     = alu_f(alu_a, alu_b, alu_op, alu_tt);
  assign alu_out   = alu_r[15:0];
  assign alu_carry = alu_r[16];
  assign alu_ovf   = alu_r[17];

  assign alu_r_n     = alu_f(alu_a_n, alu_b_n, alu_op_n, alu_tt_n);
  assign alu_out_n   = alu_r_n[15:0];
  assign alu_carry_n = alu_r_n[16];
  assign alu_ovf_n   = alu_r_n[17];

  alu_sequencer #(.W(16), .WIDE(1'b1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tt(in_tt), .in_sh_off(in_sh_off),
    .in_wide(in_wide), .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_tt(alu_tt),
    .alu_sh_off(alu_sh_off), .alu_out(alu_out), .alu_carry(alu_carry), .alu_ovf(alu_ovf),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_carry(out_carry), .out_ovf(out_ovf), .out_zero(out_zero)
  );

  alu_sequencer #(.W(16), .WIDE(1'b0)) dut_narrow (
    .clk(clk), .rst(rst), .in_valid(in_valid_n), .in_ready(in_ready_n),
    .in_a(in_a), .in_b(in_b), .in_op(in_op), .in_tt(in_tt), .in_sh_off(in_sh_off),
    .in_wide(in_wide), .alu_a(alu_a_n), .alu_b(alu_b_n), .alu_op(alu_op_n), .alu_tt(alu_tt_n),
    .alu_sh_off(alu_sh_off_n), .alu_out(alu_out_n), .alu_carry(alu_carry_n), .alu_ovf(alu_ovf_n),
    .out_valid(out_valid_n), .out_ready(out_ready_n), .out_result(out_result_n),
    .out_carry(out_carry_n), .out_ovf(out_ovf_n), .out_zero(out_zero_n)
  );

  typedef struct {
    logic [31:0] res;
    logic        c;
    logic        o;
    logic        z;
  } ref_t;

  // Whole-operation reference: one 32-bit (or 16-bit) add/sub or bitwise logic op.
  function automatic ref_t ref_f(input logic [31:0] a, input logic [31:0] b,
                                 input logic [4:0] op, input logic [3:0] tt, input logic wide);
    ref_t        r;
    logic [31:0] am, bm, mask;
    logic [32:0] s;
    mask = wide ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    am = a & mask;
    bm = b & mask;
    if (op[4]) bm = bm | (wide ? 32'h0001_0001 : 32'h0000_0001);
    r.res = '0;
    r.c   = 1'b0;
    r.o   = 1'b0;
    if (op[0]) begin
      if (op[1]) bm = ~bm & mask;
      s = {1'b0, am} + {1'b0, bm} + 33'(op[2]);
      if (wide) begin
        r.res = s[31:0];
        r.c   = s[32];
        r.o   = (am[31] == bm[31]) && (s[31] != am[31]);
      end else begin
        r.res = {16'h0000, s[15:0]};
        r.c   = s[16];
        r.o   = (am[15] == bm[15]) && (s[15] != am[15]);
      end
    end else begin
      for (int i = 0; i < 32; i++) r.res[i] = mask[i] ? tt[{am[i], bm[i]}] : 1'b0;
    end
    r.z = (r.res == 32'h0);
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Presents an op, waits for acceptance, then counts edges until out_valid.
  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [4:0] op,
                       input logic [3:0] tt, input logic wide, output int lat);
    int n;
    @(negedge clk);
    in_a = a; in_b = b; in_op = op; in_tt = tt; in_wide = wide;
    in_sh_off = 4'($urandom_range(0, 15));
    last_sh = in_sh_off;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) check("accept_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    lat = 1;
    op_at2 = '0;
    while (!out_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
      if (lat == 2) op_at2 = alu_op;
    end
  endtask

  task automatic retire();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [31:0] a, b;
    logic [4:0]  op;
    logic [3:0]  tt;
    logic        wide;
    logic [31:0] res;
    logic        c, o, z;
    int          lat;
  } vec_t;

  vec_t vecs[5];

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat;
    ref_t exp;
    logic [31:0] ra, rb, snap_res;
    logic [4:0]  rop;
    logic [3:0]  rtt;
    logic        rw, snap_c, snap_o;

    checks = 0; failures = 0;
    rst = 1'b1;
    in_valid = 1'b0; in_valid_n = 1'b0; out_ready = 1'b0; out_ready_n = 1'b0;
    in_a = '0; in_b = '0; in_op = '0; in_tt = '0; in_sh_off = '0; in_wide = 1'b0;
    last_sh = '0; op_at2 = '0;

    vecs[0] = '{32'h0000_0001, 32'h0000_FFFF, 5'b00001, 4'b0000, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 2};
    vecs[1] = '{32'h0000_FFFF, 32'h0000_0001, 5'b00001, 4'b0000, 1'b1, 32'h0001_0000, 1'b0, 1'b0, 1'b0, 3};
    vecs[2] = '{32'h0000_00F0, 32'h0000_0FF0, 5'b00000, 4'b0110, 1'b0, 32'h0000_0F00, 1'b0, 1'b0, 1'b0, 2};
    vecs[3] = '{32'h0001_0000, 32'h0000_0001, 5'b00111, 4'b0000, 1'b1, 32'h0000_FFFF, 1'b1, 1'b0, 1'b0, 3};
    vecs[4] = '{32'h0000_7FFF, 32'h0000_0001, 5'b00001, 4'b0000, 1'b0, 32'h0000_8000, 1'b0, 1'b1, 1'b0, 2};

    #2;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_result", out_result, 32'h0);
    check("rst_alu_a", 32'(alu_a), 32'h0);
    check("rst_alu_op", 32'(alu_op), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_flags", {30'h0, out_carry, out_ovf}, 32'h0);

    for (int i = 0; i < 5; i++) begin
      issue(vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].tt, vecs[i].wide, lat);
      check($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
      check($sformatf("vec%0d_result", i), out_result, vecs[i].res);
      check($sformatf("vec%0d_carry", i), 32'(out_carry), 32'(vecs[i].c));
      check($sformatf("vec%0d_ovf", i), 32'(out_ovf), 32'(vecs[i].o));
      check($sformatf("vec%0d_zero", i), 32'(out_zero), 32'(vecs[i].z));
      check($sformatf("vec%0d_alu_a_hold", i), 32'(alu_a), vecs[i].a & 32'h0000_FFFF);
      check($sformatf("vec%0d_alu_sh_off", i), 32'(alu_sh_off), 32'(last_sh));
      check($sformatf("vec%0d_alu_tt", i), 32'(alu_tt), 32'(vecs[i].tt));
      if (i == 1) check("vec1_hi_alu_op", 32'(op_at2), 32'b00101);
      retire();
      check($sformatf("vec%0d_retired", i), 32'(out_valid), 32'd0);
    end

    // Backpressure: result held for 5 clocks, then same-edge accept of the next op.
    issue(32'h0000_1234, 32'h0000_0F0F, 5'b00001, 4'b0000, 1'b0, lat);
    snap_res = out_result; snap_c = out_carry; snap_o = out_ovf;
    check("bp_result", snap_res, 32'h0000_2143);
    @(negedge clk);
    in_a = 32'h0000_00FF; in_b = 32'h0000_0F0F; in_op = 5'b00000; in_tt = 4'b1000; in_wide = 1'b0;
    in_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      check("bp_valid_hold", 32'(out_valid), 32'd1);
      check("bp_result_hold", out_result, snap_res);
      check("bp_flags_hold", {30'h0, out_carry, out_ovf}, {30'h0, snap_c, snap_o});
      check("bp_in_ready_low", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    check("bp_in_ready_release", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    out_ready = 1'b0; in_valid = 1'b0;
    check("bp_accepted_busy", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check("bp_next_valid", 32'(out_valid), 32'd1);
    check("bp_next_result", out_result, 32'h0000_000F);
    retire();

    // Reset while the wide op sits in its high pass.
    @(negedge clk);
    in_a = 32'hABCD_0001; in_b = 32'h1111_0002; in_op = 5'b00001; in_tt = '0; in_wide = 1'b1;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_hi_alu_a", 32'(alu_a), 32'h0000_ABCD);
    #2;
    rst = 1'b1;
    #1;
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd0);
    check("rst_mid_result", out_result, 32'h0);
    check("rst_mid_alu_a", 32'(alu_a), 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check("rst_mid_no_partial", 32'(out_valid), 32'd0);
    issue(32'h0000_0003, 32'h0000_0004, 5'b00001, 4'b0000, 1'b0, lat);
    check("rst_after_latency", 32'(lat), 32'd2);
    check("rst_after_result", out_result, 32'h0000_0007);
    retire();

    // Randomized ops against the whole-operation model, with random hold time.
    for (int i = 0; i < 40; i++) begin
      ra = $urandom; rb = $urandom; rop = 5'($urandom); rtt = 4'($urandom); rw = 1'($urandom);
      exp = ref_f(ra, rb, rop, rtt, rw);
      issue(ra, rb, rop, rtt, rw, lat);
      repeat ($urandom_range(0, 3)) @(posedge clk);
      #1;
      check($sformatf("rnd%0d_latency", i), 32'(lat), rw ? 32'd3 : 32'd2);
      check($sformatf("rnd%0d_result", i), out_result, exp.res);
      check($sformatf("rnd%0d_flags", i), {29'h0, out_carry, out_ovf, out_zero},
            {29'h0, exp.c, exp.o, exp.z});
      retire();
    end

    // WIDE=0 build: in_wide ignored, single pass, zero upper half.
    @(negedge clk);
    in_a = 32'h1234_FFFF; in_b = 32'h0001_0001; in_op = 5'b00001; in_tt = '0; in_wide = 1'b1;
    in_valid_n = 1'b1;
    @(posedge clk);
    #1;
    in_valid_n = 1'b0;
    @(posedge clk);
    #1;
    check("narrow_build_valid", 32'(out_valid_n), 32'd1);
    check("narrow_build_result", out_result_n, 32'h0000_0000);
    check("narrow_build_flags", {29'h0, out_carry_n, out_ovf_n, out_zero_n}, 32'b101);
    @(negedge clk);
    out_ready_n = 1'b1;
    @(posedge clk);
    #1;
    out_ready_n = 1'b0;
    check("narrow_build_retired", 32'(out_valid_n), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
